// File: rtl/sfifo_pack_pkg.sv
// Shared constants and elaboration helpers for the packing write FIFO.
package sdram_fifo_pkg;

  localparam int DEF_WR_W  = 8;
  localparam int DEF_RATIO = 2;
  localparam int DEF_DEPTH = 512;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Lane index width; never narrower than one bit so RATIO of 1 or 2 still
  // gets a real register.
  function automatic int lane_w(input int ratio);
    return (ratio <= 2) ? 1 : clog2(ratio);
  endfunction

endpackage

// File: rtl/sfifo_pack_if.sv
// Host-side bus of the packing FIFO: write/read handshakes plus status flags.
// The host drives through master, the FIFO answers through slave.
interface sfifo_pack_if import sdram_fifo_pkg::*; #(
  parameter int WR_W  = DEF_WR_W,
  parameter int RATIO = DEF_RATIO,
  parameter int DEPTH = DEF_DEPTH
) ();

  localparam int RD_W = WR_W * RATIO;
  localparam int AW   = clog2(DEPTH);

  logic            fifo_flush;
  logic            fifo_wr_en;
  logic [WR_W-1:0] fifo_wr_data;
  logic            fifo_full;
  logic            fifo_rd_en;
  logic [RD_W-1:0] fifo_rd_data;
  logic            fifo_empty;
  logic [AW:0]     fifo_rd_level;
  logic            fifo_almost_full;
  logic            fifo_burst_rdy;
  logic            fifo_wr_err;
  logic            fifo_rd_err;

  modport master (
    output fifo_flush, fifo_wr_en, fifo_wr_data, fifo_rd_en,
    input  fifo_full, fifo_rd_data, fifo_empty, fifo_rd_level,
           fifo_almost_full, fifo_burst_rdy, fifo_wr_err, fifo_rd_err
  );

  modport slave (
    input  fifo_flush, fifo_wr_en, fifo_wr_data, fifo_rd_en,
    output fifo_full, fifo_rd_data, fifo_empty, fifo_rd_level,
           fifo_almost_full, fifo_burst_rdy, fifo_wr_err, fifo_rd_err
  );

endinterface

// File: rtl/sfifo_pack_ram.sv
// Simple dual-port storage for packed words: one write port and a registered
// read port with read enable. The read register is the FIFO's rd_data, so it
// is the only part that resets; the array itself is never cleared.
module sfifo_ram #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 9,
  parameter int WRITE_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;
  logic              bypass;

  // A same-address write forwards into the read register only in write-first
  // mode; otherwise the old contents are returned.
  always_comb begin
    bypass = (WRITE_FIRST != 0) && we_i && (waddr_i == raddr_i);
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Registered read port; holds its value whenever re_i is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= bypass ? wdata_i : mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sfifo_pack.sv
// Single-clock FIFO that packs RATIO narrow write words into one wide read
// word (first word in the least significant lane) in front of the SDRAM
// write burst engine. Only completed packs are visible to the read side.
module sfifo_pack import sdram_fifo_pkg::*; #(
  parameter int WR_W      = DEF_WR_W,
  parameter int RATIO     = DEF_RATIO,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_TH  = DEPTH - 4,
  parameter int BURST_LEN = 8,
  parameter int SHOWAHEAD = 0
) (
  input logic         fifo_clk,
  input logic         rst_n,
  sfifo_pack_if.slave bus
);

  localparam int RD_W = WR_W * RATIO;
  localparam int AW   = clog2(DEPTH);
  localparam int LW   = lane_w(RATIO);

  localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AFULL_CNT = (AW+1)'(AFULL_TH);
  localparam logic [AW:0]   BURST_CNT = (AW+1)'(BURST_LEN);
  localparam logic [AW:0]   ONE_CNT   = (AW+1)'(1);

  logic [AW-1:0]   wrPtr_q, wrPtr_d;
  logic [AW-1:0]   rdPtr_q, rdPtr_d;
  logic [AW:0]     count_q, count_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic [RD_W-1:0] pack_q, pack_d;
  logic            wrErr_q, wrErr_d;
  logic            rdErr_q, rdErr_d;

  logic            full;
  logic            empty;
  logic            rdAcc;
  logic            wrAcc;
  logic            commit;
  logic [RD_W-1:0] commitWord;
  logic            ramRen;
  logic [AW-1:0]   ramRaddr;
  logic [RD_W-1:0] ramRdata;

  // Acceptance decisions. full refuses the closing lane while RAM is full,
  // but a same-cycle accepted read frees the slot so the commit may proceed.
  // Flush overrides every request.
  always_comb begin
    full       = (count_q == FULL_CNT) && (lane_q == LAST_LANE);
    empty      = (count_q == '0);
    rdAcc      = bus.fifo_rd_en && !empty && !bus.fifo_flush;
    wrAcc      = bus.fifo_wr_en && (!full || rdAcc) && !bus.fifo_flush;
    commit     = wrAcc && (lane_q == LAST_LANE);
    commitWord = pack_q;
    commitWord[(RATIO-1)*WR_W +: WR_W] = bus.fifo_wr_data;
  end

  // Next-state for pointers, lane index, fill count, pack register and the
  // error pulses.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    lane_d  = lane_q;
    pack_d  = pack_q;
    wrErr_d = 1'b0;
    rdErr_d = 1'b0;
    if (bus.fifo_flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
      lane_d  = '0;
    end else begin
      wrErr_d = bus.fifo_wr_en && !wrAcc;
      rdErr_d = bus.fifo_rd_en && empty;
      if (wrAcc) begin
        if (commit) begin
          wrPtr_d = wrPtr_q + 1'b1;
          lane_d  = '0;
        end else begin
          pack_d[lane_q*WR_W +: WR_W] = bus.fifo_wr_data;
          lane_d = lane_q + 1'b1;
        end
      end
      if (rdAcc) begin
        rdPtr_d = rdPtr_q + 1'b1;
      end
      case ({commit, rdAcc})
        2'b10:   count_d = count_q + ONE_CNT;
        2'b01:   count_d = count_q - ONE_CNT;
        default: count_d = count_q;
      endcase
    end
  end

  // Read-port steering. Registered mode reads the head on acceptance. In
  // show-ahead mode the read register always holds the head: an accepted read
  // fetches rd_ptr+1 (only if another entry will exist), and a commit into an
  // empty FIFO loads the new word through the write-first bypass. Draining the
  // last entry leaves the register untouched so the last value holds.
  always_comb begin
    ramRen   = 1'b0;
    ramRaddr = rdPtr_q;
    if (SHOWAHEAD != 0) begin
      ramRen   = (rdAcc && ((count_q > ONE_CNT) || commit)) || (empty && commit);
      ramRaddr = rdAcc ? (rdPtr_q + 1'b1) : rdPtr_q;
    end else begin
      ramRen   = rdAcc;
      ramRaddr = rdPtr_q;
    end
  end

  // State registers; reset mid-pack drops any partially assembled word.
  always_ff @(posedge fifo_clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      lane_q  <= '0;
      pack_q  <= '0;
      wrErr_q <= 1'b0;
      rdErr_q <= 1'b0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      lane_q  <= lane_d;
      pack_q  <= pack_d;
      wrErr_q <= wrErr_d;
      rdErr_q <= rdErr_d;
    end
  end

  sfifo_ram #(
    .DATA_W      (RD_W),
    .ADDR_W      (AW),
    .WRITE_FIRST (SHOWAHEAD)
  ) u_ram (
    .clk     (fifo_clk),
    .rst_n   (rst_n),
    .we_i    (commit),
    .waddr_i (wrPtr_q),
    .wdata_i (commitWord),
    .re_i    (ramRen),
    .raddr_i (ramRaddr),
    .rdata_o (ramRdata)
  );

  assign bus.fifo_rd_data     = ramRdata;
  assign bus.fifo_full        = full;
  assign bus.fifo_empty       = empty;
  assign bus.fifo_rd_level    = count_q;
  assign bus.fifo_almost_full = (count_q >= AFULL_CNT);
  assign bus.fifo_burst_rdy   = (count_q >= BURST_CNT);
  assign bus.fifo_wr_err      = wrErr_q;
  assign bus.fifo_rd_err      = rdErr_q;

endmodule
